// File: rtl/scie_fir_seq.sv
// Sequences FIR coefficient loads and sample push/read pairs onto a SCIE accelerator issue port.
// Define SCIE_SEQ_STATS_EN to add the samples_done / coefs_done counters.
module scie_fir_seq #(
    parameter int NTAPS   = 5,
    parameter int GAP     = 1,
    parameter int RD_LAT  = 1,
    parameter int OP_LOAD = 11,
    parameter int OP_PUSH = 43,
    parameter int OP_READ = 91
) (
    input  logic               clock,
    input  logic               reset,
    // Every stream transfers on a rising edge where its valid and ready are both high;
    // ready may depend on valid, and valid never depends on ready.
    input  logic               coef_valid,
    output logic               coef_ready,
    input  logic signed [31:0] coef_real,
    input  logic signed [31:0] coef_imag,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [31:0] in_real,
    input  logic signed [31:0] in_imag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [31:0] out_real,
    output logic signed [31:0] out_imag,
    output logic               io_valid,
    output logic [31:0]        io_insn,
    output logic [31:0]        io_rs2,
    output logic signed [31:0] io_rs1_real,
    output logic signed [31:0] io_rs1_imag,
    input  logic signed [31:0] io_rd_real,
    input  logic signed [31:0] io_rd_imag,
    output logic [2:0]         dbg_state
`ifdef SCIE_SEQ_STATS_EN
    ,
    output logic [15:0]        samples_done,
    output logic [15:0]        coefs_done
`endif
);

    localparam int IDXW = (NTAPS > 1) ? $clog2(NTAPS) : 1;
    localparam int CW   = 16;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NTAPS - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_LOAD, ST_PUSH, ST_GAP, ST_READ, ST_WAIT, ST_CAPT
    } state_t;

    state_t             state_q, state_d;
    logic [IDXW-1:0]    idx_q, idx_d;
    logic               loaded_q, loaded_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic signed [31:0] pay_re_q, pay_re_d;
    logic signed [31:0] pay_im_q, pay_im_d;
    logic               out_valid_q, out_valid_d;
    logic signed [31:0] out_re_q, out_re_d;
    logic signed [31:0] out_im_q, out_im_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            loaded_q    <= 1'b0;
            cnt_q       <= '0;
            pay_re_q    <= '0;
            pay_im_q    <= '0;
            out_valid_q <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            loaded_q    <= loaded_d;
            cnt_q       <= cnt_d;
            pay_re_q    <= pay_re_d;
            pay_im_q    <= pay_im_d;
            out_valid_q <= out_valid_d;
            out_re_q    <= out_re_d;
            out_im_q    <= out_im_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        loaded_d    = loaded_q;
        cnt_d       = cnt_q;
        pay_re_d    = pay_re_q;
        pay_im_d    = pay_im_q;
        out_valid_d = out_valid_q;
        out_re_d    = out_re_q;
        out_im_d    = out_im_q;
        io_valid    = 1'b0;
        io_insn     = '0;
        io_rs2      = '0;
        io_rs1_real = '0;
        io_rs1_imag = '0;
        coef_ready  = (state_q == ST_IDLE);
        // A pending coefficient always takes the slot, so it masks the sample side.
        in_ready    = (state_q == ST_IDLE) && loaded_q && !out_valid_q && !coef_valid;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (coef_valid) begin
                    state_d  = ST_LOAD;
                    pay_re_d = coef_real;
                    pay_im_d = coef_imag;
                end else if (in_valid && in_ready) begin
                    state_d  = ST_PUSH;
                    pay_re_d = in_real;
                    pay_im_d = in_imag;
                end
            end
            ST_LOAD: begin
                io_valid    = 1'b1;
                io_insn     = 32'(OP_LOAD);
                io_rs2      = 32'(idx_q);
                io_rs1_real = pay_re_q;
                io_rs1_imag = pay_im_q;
                if (idx_q == IDX_LAST) begin
                    idx_d    = '0;
                    loaded_d = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
                state_d = ST_IDLE;
            end
            ST_PUSH: begin
                io_valid    = 1'b1;
                io_insn     = 32'(OP_PUSH);
                io_rs1_real = pay_re_q;
                io_rs1_imag = pay_im_q;
                if (GAP > 0) begin
                    state_d = ST_GAP;
                    cnt_d   = CW'(GAP - 1);
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    state_d = ST_READ;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_READ: begin
                io_valid = 1'b1;
                io_insn  = 32'(OP_READ);
                // CAPT is itself the RD_LAT-th cycle, so WAIT covers the RD_LAT-1 before it.
                if (RD_LAT > 1) begin
                    state_d = ST_WAIT;
                    cnt_d   = CW'(RD_LAT - 2);
                end else begin
                    state_d = ST_CAPT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_CAPT;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_CAPT: begin
                out_re_d    = io_rd_real;
                out_im_d    = io_rd_imag;
                out_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign out_valid = out_valid_q;
    assign out_real  = out_re_q;
    assign out_imag  = out_im_q;
    assign dbg_state = state_q;

`ifdef SCIE_SEQ_STATS_EN
    logic [15:0] samples_q, coefs_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            samples_q <= '0;
            coefs_q   <= '0;
        end else begin
            if (out_valid_q && out_ready) begin
                samples_q <= samples_q + 1'b1;
            end
            if (state_q == ST_LOAD) begin
                coefs_q <= coefs_q + 1'b1;
            end
        end
    end

    assign samples_done = samples_q;
    assign coefs_done   = coefs_q;
`endif

endmodule
